// File: rtl/dekatron_pkg.sv
// dekatron_pkg: shared digit type, op/state encodings and BCD saturation helper
package dekatron_pkg;

    localparam int DEKATRON_WIDTH = 4;

    typedef logic [DEKATRON_WIDTH-1:0] digit_t;

    typedef enum logic [1:0] {OP_INC, OP_DEC, OP_SET, OP_CLR} op_t;

    typedef enum logic [1:0] {IDLE, STEP, CARRY, LOAD} state_t;

    function automatic digit_t bcd_sat(input digit_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/dekatron_digit.sv
// dekatron_digit: one BCD dekatron digit register
//   Clk, Rst_n         : clock, async active-low reset
//   up, down, load, d  : step-up / step-down / parallel-load strobes and load value
//   q                  : current digit
//   carry, borrow      : strobed wrap-out (up at 9, down at 0)
//   zero, nine, match_top : q==0, q==9, q==TOP
module dekatron_digit
    import dekatron_pkg::*;
#(
    parameter digit_t TOP = 4'd9
) (
    input  logic   Clk,
    input  logic   Rst_n,
    input  logic   up,
    input  logic   down,
    input  logic   load,
    input  digit_t d,
    output digit_t q,
    output logic   carry,
    output logic   borrow,
    output logic   zero,
    output logic   nine,
    output logic   match_top
);

    assign zero      = q == 4'd0;
    assign nine      = q == 4'd9;
    assign match_top = q == TOP;
    assign carry     = up && nine;
    assign borrow    = down && zero;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            q <= '0;
        else if (load)
            q <= d;
        else if (up)
            q <= nine ? 4'd0 : q + 4'd1;
        else if (down)
            q <= zero ? 4'd9 : q - 4'd1;
    end

endmodule

// File: rtl/dekatron_step_counter.sv
// dekatron_step_counter: multi-digit BCD counter with dekatron step and ripple-carry timing
//   Clk, Rst_n   : clock, async active-low reset
//   Request, Op  : command strobe (accepted on rising edge), 00 INC 01 DEC 10 SET 11 CLR
//   Steps, In    : burst length for INC/DEC, BCD load value
//   Ready, Zero, Top, Wrap, Out : idle flag, Out==0, Out at top, boundary pulse, BCD value
//   DEKATRON_STEP_BURST_EN : when defined, INC/DEC run Steps unit steps (0 means 1)
module dekatron_step_counter
    import dekatron_pkg::*;
#(
    parameter int D_NUM          = 3,
    parameter int STEP_CYCLES    = 4,
    parameter int WRITE_CYCLES   = 10,
    parameter int STEP_W         = 4,
    parameter int TOP_LIMIT_MODE = 0,
    parameter logic [D_NUM*DEKATRON_WIDTH-1:0] TOP_VALUE = {4'd5, 4'd5, 4'd5}
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic                            Request,
    input  logic [1:0]                      Op,
    input  logic [STEP_W-1:0]               Steps,
    input  logic [D_NUM*DEKATRON_WIDTH-1:0] In,
    output logic                            Ready,
    output logic                            Zero,
    output logic                            Top,
    output logic                            Wrap,
    output logic [D_NUM*DEKATRON_WIDTH-1:0] Out
);

    localparam int TMAX = (STEP_CYCLES > WRITE_CYCLES) ? STEP_CYCLES : WRITE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int SW   = (D_NUM > 1) ? $clog2(D_NUM) : 1;

    state_t                            state, state_n;
    op_t                               op_q;
    logic [TW-1:0]                     timer;
    logic [SW-1:0]                     dsel;
    logic [D_NUM*DEKATRON_WIDTH-1:0]   in_q;
    logic                              req_q, wrapw, wrap_q;
    logic                              accept, start, more, step_done, load_done;
    logic                              last_digit, act_c, lim_in, lim_q, zero_all, top_all;
    logic [D_NUM-1:0]                  up, dn, ld, cy, bw, zr, nn, mt;
    digit_t                            ld_val [D_NUM];

    for (genvar g = 0; g < D_NUM; g++) begin : g_digit
        assign up[g] = step_done && dsel == SW'(g) && op_q == OP_INC;
        assign dn[g] = step_done && dsel == SW'(g) && op_q == OP_DEC;
        assign ld[g] = load_done;
        // wrapw marks a range-limit rewrite: INC wraps to 0, DEC wraps to TOP_VALUE
        assign ld_val[g] = wrapw ? ((op_q == OP_DEC) ? TOP_VALUE[g*4 +: 4] : 4'd0)
                                 : ((op_q == OP_SET) ? bcd_sat(in_q[g*4 +: 4]) : 4'd0);
        dekatron_digit #(.TOP(TOP_VALUE[g*4 +: 4])) u_digit (
            .Clk      (Clk),
            .Rst_n    (Rst_n),
            .up       (up[g]),
            .down     (dn[g]),
            .load     (ld[g]),
            .d        (ld_val[g]),
            .q        (Out[g*4 +: 4]),
            .carry    (cy[g]),
            .borrow   (bw[g]),
            .zero     (zr[g]),
            .nine     (nn[g]),
            .match_top(mt[g])
        );
    end

    assign zero_all   = &zr;
    assign top_all    = (TOP_LIMIT_MODE != 0) ? &mt : &nn;
    assign act_c      = |(cy | bw);
    assign last_digit = dsel == SW'(D_NUM - 1);
    assign accept     = state == IDLE && Request && !req_q;
    assign step_done  = state == STEP && timer == TW'(STEP_CYCLES);
    assign load_done  = state == LOAD && timer == TW'(WRITE_CYCLES);
    assign lim_in     = TOP_LIMIT_MODE != 0 && ((Op == OP_INC && top_all) || (Op == OP_DEC && zero_all));
    assign lim_q      = TOP_LIMIT_MODE != 0 && ((op_q == OP_INC && top_all) || (op_q == OP_DEC && zero_all));
    assign start      = accept || (state == CARRY && more);
    assign Ready      = state == IDLE && !Request;
    assign Zero       = zero_all;
    assign Top        = top_all;
    assign Wrap       = wrap_q;

`ifdef DEKATRON_STEP_BURST_EN
    logic [STEP_W-1:0] rem;
    assign more = (op_q == OP_INC || op_q == OP_DEC) && rem > STEP_W'(1);
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            rem <= '0;
        else if (accept)
            rem <= (Steps == '0) ? STEP_W'(1) : Steps;
        else if (state == CARRY && more)
            rem <= rem - 1'b1;
    end
`else
    logic unused_steps;
    assign unused_steps = ^Steps;
    assign more = 1'b0;
`endif

    // a carry into a higher digit keeps the ripple in STEP; CARRY decides next unit step or finish
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !accept ? IDLE : (Op[1] || lim_in) ? LOAD : STEP;
            STEP:    state_n = (step_done && !(act_c && !last_digit)) ? CARRY : STEP;
            LOAD:    state_n = load_done ? CARRY : LOAD;
            CARRY:   state_n = !more ? IDLE : lim_q ? LOAD : STEP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            op_q   <= OP_INC;
            timer  <= '0;
            dsel   <= '0;
            in_q   <= '0;
            req_q  <= 1'b0;
            wrapw  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_n;
            req_q  <= Request;
            wrap_q <= (step_done && act_c && last_digit) || (load_done && wrapw);
            if (accept) begin
                op_q <= op_t'(Op);
                in_q <= In;
            end
            if (start) begin
                timer <= TW'(1);
                dsel  <= '0;
                wrapw <= accept ? lim_in : lim_q;
            end else if (step_done) begin
                timer <= TW'(1);
                dsel  <= dsel + 1'b1;
            end else if (state == STEP || state == LOAD)
                timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_dekatron_step_counter.sv
// tb_dekatron_step_counter: random and directed checks of two counter builds against a decimal model
module tb_dekatron_step_counter;

    localparam int S    = 4;
    localparam int WR   = 10;
    localparam int TOPV = 555;

    logic             Clk = 1'b0, Rst_n = 1'b0, Request = 1'b0;
    logic [1:0]       Op = '0;
    logic [3:0]       Steps = '0;
    logic [11:0]      In = '0;
    logic [1:0]       rdy, zer, tp, wrp;
    logic [1:0][11:0] outs;

    int vectors = 0, miscompares = 0;
    int mv [2] = '{0, 0};
    int eo [2][512];
    bit ew [2][512];
    int ne [2];

    dekatron_step_counter #(.TOP_LIMIT_MODE(0)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .Request(Request), .Op(Op), .Steps(Steps), .In(In),
        .Ready(rdy[0]), .Zero(zer[0]), .Top(tp[0]), .Wrap(wrp[0]), .Out(outs[0])
    );

    dekatron_step_counter #(.TOP_LIMIT_MODE(1), .TOP_VALUE(12'h555)) u_lim (
        .Clk(Clk), .Rst_n(Rst_n), .Request(Request), .Op(Op), .Steps(Steps), .In(In),
        .Ready(rdy[1]), .Zero(zer[1]), .Top(tp[1]), .Wrap(wrp[1]), .Out(outs[1])
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dig(input int v, input int j);
        return (v / (10 ** j)) % 10;
    endfunction

    function automatic int bcd(input int v);
        return (dig(v, 2) << 8) | (dig(v, 1) << 4) | dig(v, 0);
    endfunction

    function automatic int from_in(input int x);
        int v = 0;
        for (int j = 0; j < 3; j++) begin
            int d = (x >> (4 * j)) & 15;
            v += ((d > 9) ? 9 : d) * (10 ** j);
        end
        return v;
    endfunction

    task automatic put(input int k, input int c, input int len, input int nv, input bit w);
        for (int x = c + 1; x < c + len; x++) begin
            eo[k][x] = eo[k][c];
            ew[k][x] = 1'b0;
        end
        eo[k][c + len] = nv;
        ew[k][c + len] = w;
    endtask

    // expected Out/Wrap per cycle after acceptance, from decimal arithmetic on the counter value
    task automatic build(input int k, input int op, input int steps, input int inv);
        int c, v, n, nd, p, nv;
        v = mv[k];
        c = 0;
        eo[k][0] = v;
        ew[k][0] = 1'b0;
        if (op >= 2) begin
            v = (op == 2) ? from_in(inv) : 0;
            put(k, 0, WR, v, 1'b0);
            c = WR;
        end else begin
            n = 1;
`ifdef DEKATRON_STEP_BURST_EN
            n = (steps == 0) ? 1 : steps;
`endif
            for (int u = 0; u < n; u++) begin
                if (u > 0) begin
                    c++;
                    eo[k][c] = v;
                    ew[k][c] = 1'b0;
                end
                if (k == 1 && op == 0 && v == TOPV) begin
                    put(k, c, WR, 0, 1'b1);
                    c += WR;
                    v = 0;
                end else if (k == 1 && op == 1 && v == 0) begin
                    put(k, c, WR, TOPV, 1'b1);
                    c += WR;
                    v = TOPV;
                end else begin
                    nd = 1;
                    while (nd < 3 && dig(v, nd - 1) == ((op == 0) ? 9 : 0)) nd++;
                    nv = v;
                    for (int j = 1; j <= nd; j++) begin
                        p  = 10 ** j;
                        nv = v - v % p + ((op == 0) ? (v % p + 1) % p : (v % p + p - 1) % p);
                        put(k, c, S, nv, j == 3 && dig(v, 2) == ((op == 0) ? 9 : 0));
                        c += S;
                    end
                    v = nv;
                end
            end
        end
        ne[k] = c;
        for (int x = c + 1; x < 512; x++) begin
            eo[k][x] = v;
            ew[k][x] = 1'b0;
        end
        mv[k] = v;
    endtask

    task automatic cmd(input int op, input int steps, input int inv, input bit hold);
        int last;
        @(negedge Clk);
        Op      = 2'(op);
        Steps   = 4'(steps);
        In      = 12'(inv);
        Request = 1'b1;
        build(0, op, steps, inv);
        build(1, op, steps, inv);
        last = ((ne[0] > ne[1]) ? ne[0] : ne[1]) + 1;
        for (int c = 0; c <= last; c++) begin
            @(negedge Clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("out%0d@%0d", k, c), 32'(outs[k]), 32'(bcd(eo[k][c])));
                check($sformatf("wrap%0d@%0d", k, c), 32'(wrp[k]), 32'(ew[k][c]));
                check($sformatf("zero%0d@%0d", k, c), 32'(zer[k]), 32'(eo[k][c] == 0));
                check($sformatf("top%0d@%0d", k, c), 32'(tp[k]), 32'(eo[k][c] == ((k == 1) ? TOPV : 999)));
                check($sformatf("ready%0d@%0d", k, c), 32'(rdy[k]), 32'(c > ne[k] && !Request));
            end
            if (c == 0) Request = hold;
            Op    = 2'($urandom);
            Steps = 4'($urandom);
            In    = 12'($urandom);
        end
        if (hold) begin
            repeat (3) begin
                @(negedge Clk);
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("hold_out%0d", k), 32'(outs[k]), 32'(bcd(mv[k])));
                    check($sformatf("hold_ready%0d", k), 32'(rdy[k]), 32'(0));
                end
            end
            Request = 1'b0;
            #1;
            for (int k = 0; k < 2; k++) check($sformatf("release_ready%0d", k), 32'(rdy[k]), 32'(1));
        end
    endtask

    initial begin
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_out%0d", k), 32'(outs[k]), 32'(0));
            check($sformatf("rst_zero%0d", k), 32'(zer[k]), 32'(1));
            check($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'(1));
            check($sformatf("rst_wrap%0d", k), 32'(wrp[k]), 32'(0));
        end
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;

        cmd(0, 1, 0, 1'b0);
        cmd(2, 1, 'h099, 1'b0);
        cmd(0, 1, 0, 1'b0);
        cmd(3, 1, 0, 1'b0);
        cmd(1, 1, 0, 1'b0);
        cmd(0, 1, 0, 1'b0);
        cmd(1, 1, 0, 1'b0);
        cmd(2, 1, 'h3A7, 1'b0);
        cmd(3, 1, 0, 1'b1);
        cmd(2, 1, 'h095, 1'b0);
        cmd(0, 12, 0, 1'b0);
        cmd(2, 1, 'h555, 1'b0);
        cmd(0, 3, 0, 1'b0);

        cmd(2, 1, 'h099, 1'b0);
        @(negedge Clk);
        Op      = 2'd0;
        Steps   = 4'd1;
        Request = 1'b1;
        @(negedge Clk);
        Request = 1'b0;
        repeat (5) @(negedge Clk);
        for (int k = 0; k < 2; k++) check($sformatf("mid_out%0d", k), 32'(outs[k]), 32'h090);
        Rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("mid_rst_out%0d", k), 32'(outs[k]), 32'(0));
            check($sformatf("mid_rst_zero%0d", k), 32'(zer[k]), 32'(1));
            check($sformatf("mid_rst_ready%0d", k), 32'(rdy[k]), 32'(1));
            check($sformatf("mid_rst_wrap%0d", k), 32'(wrp[k]), 32'(0));
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        mv = '{0, 0};
        cmd(0, 1, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int r, op, inv;
            r   = $urandom_range(0, 7);
            op  = (r < 3) ? 0 : (r < 6) ? 1 : (r == 6) ? 2 : 3;
            inv = (r == 6 && ($urandom & 1)) ? ((($urandom & 1) != 0) ? 'h999 : 'h555) : int'($urandom & 'hFFF);
            cmd(op, $urandom_range(0, 15), inv, ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
